// File: rtl/sc_buttonconditioner.sv
// sc_buttonconditioner
//   Conditions the five raw active-low push-buttons (start, up, down, left,
//   right) before they reach the point state machine. Each channel has a
//   2-FF synchronizer, a debounce filter and optional auto-repeat. While a
//   button stays held, auto-repeat inserts a one-cycle release gap so that
//   the downstream machine, which re-arms only after all buttons release,
//   sees repeated presses.
//
// Ports (sc_buttonconditioner):
//   SC_STATEMACHINEPOINT_CLOCK_50        in  1  system clock (50 MHz)
//   SC_STATEMACHINEPOINT_RESET_InHigh    in  1  async reset, active high
//   SC_BUTTONCONDITIONER_rawButtons_InLow in 5  raw buttons, 0 = pressed,
//                                               [0]start [1]up [2]down
//                                               [3]left [4]right
//   SC_BUTTONCONDITIONER_*Button_OutLow  out 1  conditioned levels, 0 = pressed
//
// Ports (sc_buttonconditioner_channel):
//   clk  in  1  system clock
//   rst  in  1  async reset, active high
//   raw  in  1  raw asynchronous button, 0 = pressed
//   btn  out 1  conditioned registered level, 0 = pressed

// One button channel.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | button released, output 1
// HELD  | button pressed, output 0, counting towards the first repeat
// GAP   | one-cycle artificial release inserted by auto-repeat, output 1
// RPT   | repeat press, output 0, counting towards the next gap
module sc_buttonconditioner_channel #(
  parameter int       DEBOUNCE_CYCLES = 1000000,
  parameter int       REPEAT_DELAY    = 25000000,
  parameter int       REPEAT_PERIOD   = 5000000,
  parameter int       CNT_WIDTH       = 25,
  parameter bit       REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic btn
);

  localparam logic [CNT_WIDTH-1:0] DB_LAST     = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_GAP  = 2'd2,
    ST_RPT  = 2'd3
  } state_t;

  logic                 sync1;
  logic                 sync2;
  logic                 level;
  logic [CNT_WIDTH-1:0] db_cnt;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] rpt_q;
  logic [CNT_WIDTH-1:0] rpt_d;
  logic                 btn_q;
  logic                 btn_d;

  // Synchronizer and debounce. The counter measures how many consecutive
  // cycles the synchronized input has disagreed with the debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      level  <= 1'b1;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rpt_q   <= '0;
      btn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rpt_q   <= rpt_d;
      btn_q   <= btn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rpt_d   = rpt_q;
    case (state_q)
      ST_IDLE: begin
        if (!level) begin
          state_d = ST_HELD;
          rpt_d   = '0;
        end
      end
      ST_HELD: begin
        if (level) begin
          state_d = ST_IDLE;
        end else if (rpt_q == DELAY_LAST) begin
          // Without repeat the counter parks at its terminal value.
          if (REPEAT_EN) begin
            state_d = ST_GAP;
          end
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (!level) begin
          state_d = ST_RPT;
          rpt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RPT: begin
        if (level) begin
          state_d = ST_IDLE;
        end else if (rpt_q == PERIOD_LAST) begin
          state_d = ST_GAP;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rpt_d   = '0;
      end
    endcase
    // Output is registered from the next state so it is a clean Moore level.
    btn_d = !((state_d == ST_HELD) || (state_d == ST_RPT));
  end

  assign btn = btn_q;

endmodule

module sc_buttonconditioner #(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         REPEAT_DELAY    = 25000000,
  parameter int         REPEAT_PERIOD   = 5000000,
  parameter logic [4:0] REPEAT_MASK     = 5'b11100,
  parameter int         CNT_WIDTH       = 25
) (
  input  logic       SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic       SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic [4:0] SC_BUTTONCONDITIONER_rawButtons_InLow,
  output logic       SC_BUTTONCONDITIONER_startButton_OutLow,
  output logic       SC_BUTTONCONDITIONER_upButton_OutLow,
  output logic       SC_BUTTONCONDITIONER_downButton_OutLow,
  output logic       SC_BUTTONCONDITIONER_leftButton_OutLow,
  output logic       SC_BUTTONCONDITIONER_rightButton_OutLow
);

  logic [4:0] cond;

  for (genvar i = 0; i < 5; i++) begin : g_chan
    sc_buttonconditioner_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_WIDTH       (CNT_WIDTH),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_chan (
      .clk (SC_STATEMACHINEPOINT_CLOCK_50),
      .rst (SC_STATEMACHINEPOINT_RESET_InHigh),
      .raw (SC_BUTTONCONDITIONER_rawButtons_InLow[i]),
      .btn (cond[i])
    );
  end

  assign SC_BUTTONCONDITIONER_startButton_OutLow = cond[0];
  assign SC_BUTTONCONDITIONER_upButton_OutLow    = cond[1];
  assign SC_BUTTONCONDITIONER_downButton_OutLow  = cond[2];
  assign SC_BUTTONCONDITIONER_leftButton_OutLow  = cond[3];
  assign SC_BUTTONCONDITIONER_rightButton_OutLow = cond[4];

endmodule

// File: tb/tb_sc_buttonconditioner.sv
// tb_sc_buttonconditioner
//   Self-checking bench for sc_buttonconditioner with short timing
//   parameters. A reference model predicts every output each cycle: it
//   tracks the debounced level and, from how long that level has been low,
//   derives the expected repeat pattern arithmetically.
module tb_sc_buttonconditioner;

  localparam int         D    = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 5;
  localparam logic [4:0] MASK = 5'b11100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] raw = 5'b11111;
  logic       o_start, o_up, o_down, o_left, o_right;
  logic [4:0] outs;

  int errors = 0;
  int checks = 0;

  sc_buttonconditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .REPEAT_MASK     (MASK),
    .CNT_WIDTH       (8)
  ) dut (
    .SC_STATEMACHINEPOINT_CLOCK_50           (clk),
    .SC_STATEMACHINEPOINT_RESET_InHigh       (rst),
    .SC_BUTTONCONDITIONER_rawButtons_InLow   (raw),
    .SC_BUTTONCONDITIONER_startButton_OutLow (o_start),
    .SC_BUTTONCONDITIONER_upButton_OutLow    (o_up),
    .SC_BUTTONCONDITIONER_downButton_OutLow  (o_down),
    .SC_BUTTONCONDITIONER_leftButton_OutLow  (o_left),
    .SC_BUTTONCONDITIONER_rightButton_OutLow (o_right)
  );

  assign outs = {o_right, o_left, o_down, o_up, o_start};

  always #5 clk = ~clk;

  // Reference model state.
  logic m_s1 [5];
  logic m_s2 [5];
  logic m_lvl[5];
  int   m_run[5];
  int   m_held[5];  // consecutive edges at which the channel saw a low level

  task automatic model_reset();
    for (int c = 0; c < 5; c++) begin
      m_s1[c] = 1'b1; m_s2[c] = 1'b1; m_lvl[c] = 1'b1;
      m_run[c] = 0;   m_held[c] = 0;
    end
  endtask

  task automatic model_step(input logic [4:0] r);
    for (int c = 0; c < 5; c++) begin
      int nh;
      nh = (m_lvl[c] == 1'b0) ? m_held[c] + 1 : 0;
      if (m_s2[c] != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_lvl[c] = m_s2[c];
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      m_s2[c]   = m_s1[c];
      m_s1[c]   = r[c];
      m_held[c] = nh;
    end
  endtask

  function automatic logic [4:0] model_outs();
    logic [4:0] v;
    for (int c = 0; c < 5; c++) begin
      int p;
      p = m_held[c] - 1;
      if (m_held[c] == 0)        v[c] = 1'b1;
      else if (!MASK[c])         v[c] = 1'b0;
      else if (p < RD)           v[c] = 1'b0;
      else                       v[c] = (((p - RD) % (RP + 1)) == 0);
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%b expected=%b", name, $time, got, exp);
    end
  endtask

  // One clock cycle: drive raw, take the edge, advance the model, compare.
  task automatic cyc(input logic [4:0] r);
    raw = r;
    @(posedge clk);
    model_step(r);
    #1;
    chk("model", outs, model_outs());
  endtask

  typedef struct {
    logic [4:0] raw;
    int         n;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // outputs ordered {right,left,down,up,start}
    // down: 10 low, gap, 5 low, gap, then release mid-repeat
    tbl.push_back('{5'b11011,  6, 5'b11111});
    tbl.push_back('{5'b11011,  1, 5'b11011});
    tbl.push_back('{5'b11011,  9, 5'b11011});
    tbl.push_back('{5'b11011,  1, 5'b11111});
    tbl.push_back('{5'b11011,  1, 5'b11011});
    tbl.push_back('{5'b11011,  4, 5'b11011});
    tbl.push_back('{5'b11011,  1, 5'b11111});
    tbl.push_back('{5'b11111,  5, 5'b11011});
    tbl.push_back('{5'b11111,  1, 5'b11111});
    tbl.push_back('{5'b11111,  2, 5'b11111});
    tbl.push_back('{5'b11111, 10, 5'b11111});
    // start: no repeat, stays low while held
    tbl.push_back('{5'b11110,  7, 5'b11110});
    tbl.push_back('{5'b11110, 30, 5'b11110});
    tbl.push_back('{5'b11111,  6, 5'b11110});
    tbl.push_back('{5'b11111,  1, 5'b11111});
    tbl.push_back('{5'b11111, 10, 5'b11111});

    model_reset();

    // Reset with all buttons pressed: outputs released without a clock edge.
    raw = 5'b00000;
    #2 rst = 1'b1;
    #1 chk("reset_async", outs, 5'b11111);
    @(posedge clk); #1 chk("reset_hold", outs, 5'b11111);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(5'b00000);
      chk("reset_left_latency", {4'b0, o_left}, (k >= 6) ? 5'd0 : 5'd1);
    end
    repeat (30) cyc(5'b00000);
    repeat (20) cyc(5'b11111);
    chk("reset_idle", outs, 5'b11111);

    // Table-driven vectors.
    for (int t = 0; t < tbl.size(); t++) begin
      repeat (tbl[t].n) cyc(tbl[t].raw);
      chk($sformatf("table[%0d]", t), outs, tbl[t].exp);
    end

    // Bounce rejection on left.
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 3; k++) begin
        cyc(5'b10111);
        chk("bounce_left", {4'b0, o_left}, 5'd1);
      end
      cyc(5'b11111);
      chk("bounce_left", {4'b0, o_left}, 5'd1);
    end
    for (int k = 0; k < 8; k++) begin
      cyc(5'b10111);
      chk("steady_left", {4'b0, o_left}, (k >= 6) ? 5'd0 : 5'd1);
    end
    repeat (20) cyc(5'b11111);

    // Simultaneous right + up, then release up only.
    for (int k = 0; k < 8; k++) begin
      cyc(5'b01101);
      chk("simul_fall", {3'b0, o_right, o_up}, (k >= 6) ? 5'd0 : 5'd3);
    end
    for (int k = 0; k < 25; k++) begin
      cyc(5'b01111);
      if (k >= 6) chk("up_released", {4'b0, o_up}, 5'd1);
    end
    repeat (20) cyc(5'b11111);

    // Reset during a repeat low phase of down.
    repeat (19) cyc(5'b11011);
    chk("pre_reset_rpt_low", {4'b0, o_down}, 5'd0);
    rst = 1'b1;
    model_reset();
    #1 chk("reset_mid_repeat", outs, 5'b11111);
    @(posedge clk); #1 chk("reset_mid_hold", outs, 5'b11111);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 21; k++) begin
      cyc(5'b11011);
      chk("post_reset_down", {4'b0, o_down},
          (k < 6 || k == 16) ? 5'd1 : 5'd0);
    end
    repeat (20) cyc(5'b11111);

    // Randomized held levels against the model.
    for (int s = 0; s < 70; s++) begin
      logic [4:0] r;
      int n;
      r = 5'($urandom_range(0, 31));
      n = $urandom_range(1, 30);
      repeat (n) cyc(r);
    end
    repeat (20) cyc(5'b11111);
    chk("final_idle", outs, 5'b11111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
